// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: shares one 2:1 mux between two valid/ready requesters.
// Round-robin by default; define MUX2_ARB_FIXED_PRIO_EN for fixed priority to d0.
module mux2_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d0_valid,
    input  logic [WIDTH-1:0] d0_data,
    output logic             d0_ready,
    input  logic             d1_valid,
    input  logic [WIDTH-1:0] d1_data,
    output logic             d1_ready,
    output logic             s,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    output logic             y_src,
    input  logic             y_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_data_q, y_data_d;
    logic             y_src_q, y_src_d;
    logic             last_grant_q, last_grant_d;
    logic             s_q, s_d;

    logic             pick1;
    logic             gnt0, gnt1;
    logic             load_ok;
    logic             xfer;

    // Contention tie-break: opposite of the last winner, or d0 when fixed.
    always_comb begin
`ifdef MUX2_ARB_FIXED_PRIO_EN
        pick1 = 1'b0;
`else
        pick1 = !last_grant_q;
`endif
    end

    // Grant decode; s holds its last value when nobody requests.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (1'b1)
            (d0_valid && d1_valid):  begin
                gnt1 = pick1;
                gnt0 = !pick1;
            end
            (d0_valid && !d1_valid): gnt0 = 1'b1;
            (!d0_valid && d1_valid): gnt1 = 1'b1;
            default: ;
        endcase
        s_d = s_q;
        if (gnt0) s_d = 1'b0;
        if (gnt1) s_d = 1'b1;
    end

    // Slot can load when empty or draining this cycle.
    always_comb begin
        load_ok  = (state_q == EMPTY) || y_ready;
        d0_ready = gnt0 && load_ok;
        d1_ready = gnt1 && load_ok;
        xfer     = (d0_valid && d0_ready) || (d1_valid && d1_ready);
        s        = s_d;
    end

    // Output slot FSM and capture of the selected word.
    always_comb begin
        state_d      = state_q;
        y_data_d     = y_data_q;
        y_src_d      = y_src_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            EMPTY: if (xfer) state_d = FULL;
            FULL:  if (!xfer && y_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (xfer) begin
            y_data_d     = s_d ? d1_data : d0_data;
            y_src_d      = s_d;
            last_grant_d = s_d;
        end
    end

    // State registers; reset discards the slot immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EMPTY;
            y_data_q     <= '0;
            y_src_q      <= 1'b0;
            last_grant_q <= 1'b1;
            s_q          <= 1'b0;
        end else begin
            state_q      <= state_d;
            y_data_q     <= y_data_d;
            y_src_q      <= y_src_d;
            last_grant_q <= last_grant_d;
            s_q          <= s_d;
        end
    end

    assign y_valid = (state_q == FULL);
    assign y_data  = y_data_q;
    assign y_src   = y_src_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: directed steps against a small arbiter model,
// with accepted words queued and compared when they reach the slot.
module tb_mux2_rr_arbiter;

    logic       clk;
    logic       rst;
    logic       d0_valid;
    logic [7:0] d0_data;
    logic       d0_ready;
    logic       d1_valid;
    logic [7:0] d1_data;
    logic       d1_ready;
    logic       s;
    logic       y_valid;
    logic [7:0] y_data;
    logic       y_src;
    logic       y_ready;

    int vectors;
    int miscompares;

    logic [8:0] sb[$];
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_src;
    logic       m_last;
    logic       m_s;

    mux2_rr_arbiter #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .d0_valid (d0_valid),
        .d0_data  (d0_data),
        .d0_ready (d0_ready),
        .d1_valid (d1_valid),
        .d1_data  (d1_data),
        .d1_ready (d1_ready),
        .s        (s),
        .y_valid  (y_valid),
        .y_data   (y_data),
        .y_src    (y_src),
        .y_ready  (y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_src   = 1'b0;
        m_last  = 1'b1;
        m_s     = 1'b0;
        sb.delete();
    endtask

    task automatic check_slot(input string tag);
        chk({tag, ".y_valid"}, {31'b0, y_valid}, {31'b0, m_valid});
        chk({tag, ".y_data"},  {24'b0, y_data},  {24'b0, m_data});
        chk({tag, ".y_src"},   {31'b0, y_src},   {31'b0, m_src});
    endtask

    task automatic step(input string tag,
                        input logic v0, input logic [7:0] a0,
                        input logic v1, input logic [7:0] a1,
                        input logic yr);
        logic       g0, g1, lok, xf;
        logic [8:0] e;
        d0_valid = v0;
        d0_data  = a0;
        d1_valid = v1;
        d1_data  = a1;
        y_ready  = yr;
        #1;
`ifdef MUX2_ARB_FIXED_PRIO_EN
        g1 = v1 && !v0;
`else
        g1 = v1 && (!v0 || !m_last);
`endif
        g0 = v0 && !g1;
        if (g0 || g1) m_s = g1;
        lok = !m_valid || yr;
        xf  = (g0 || g1) && lok;
        chk({tag, ".s"},        {31'b0, s},        {31'b0, m_s});
        chk({tag, ".d0_ready"}, {31'b0, d0_ready}, {31'b0, g0 && lok});
        chk({tag, ".d1_ready"}, {31'b0, d1_ready}, {31'b0, g1 && lok});
        if (xf) begin
            sb.push_back({g1, g1 ? a1 : a0});
            m_last = g1;
        end
        @(posedge clk);
        #1;
        if (xf) begin
            e       = sb.pop_front();
            m_data  = e[7:0];
            m_src   = e[8];
            m_valid = 1'b1;
        end else if (yr) begin
            m_valid = 1'b0;
        end
        check_slot(tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst      = 1'b1;
        d0_valid = 1'b0;
        d0_data  = 8'h00;
        d1_valid = 1'b0;
        d1_data  = 8'h00;
        y_ready  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_slot("reset");
        rst = 1'b0;

        step("single0", 1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);
        step("drain0",  1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step("single1", 1'b0, 8'h00, 1'b1, 8'h5A, 1'b1);
        step("idle",    1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 4; i++)
            step("contend", 1'b1, 8'h11, 1'b1, 8'h22, 1'b1);

        for (int i = 0; i < 3; i++)
            step("bp_hold", 1'b1, 8'h33, 1'b1, 8'h44, 1'b0);
        step("bp_pass", 1'b1, 8'h33, 1'b1, 8'h44, 1'b1);
        step("bp_next", 1'b1, 8'h33, 1'b1, 8'h44, 1'b1);
        step("drain1",  1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        step("wd_load", 1'b1, 8'h66, 1'b0, 8'h00, 1'b0);
        step("wd_d1",   1'b0, 8'h00, 1'b1, 8'h77, 1'b0);
        step("wd_gone", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        step("wd_drn",  1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        step("pre_rst", 1'b0, 8'h00, 1'b1, 8'h99, 1'b0);
        d1_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_slot("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_rst", 1'b1, 8'hC3, 1'b1, 8'h3C, 1'b1);
        step("post_rst2", 1'b1, 8'hC3, 1'b1, 8'h3C, 1'b1);
        step("tail",    1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux2_rr_arbiter.md
# mux2_rr_arbiter

- Shares one 2:1 datapath mux between two independent requesters using valid/ready handshakes.
- Picks a winner each cycle: round-robin by default, fixed priority when configured.
- Drives the mux select and captures the selected word into a one-entry output register.
- Sits between two producer streams and a single downstream consumer; it is the sequencing layer for the 2:1 select path.

## Interface
- WIDTH, 8, data width of each requester and of the output.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset.
- d0_valid  input  1  requester 0 has a word.
- d0_data  input  WIDTH  requester 0 word.
- d0_ready  output  1  requester 0 word accepted this cycle.
- d1_valid  input  1  requester 1 has a word.
- d1_data  input  WIDTH  requester 1 word.
- d1_ready  output  1  requester 1 word accepted this cycle.
- s  output  1  combinational mux select for this cycle's grant (0 = D0, 1 = D1).
- y_valid  output  1  output register holds a word.
- y_data  output  WIDTH  registered output word.
- y_src  output  1  source index of the word in y_data.
- y_ready  input  1  consumer accepts y_data this cycle.

## Operation
- Clock: one clock, clk. Reset: rst is asynchronous and active-high.
- Reset values: y_valid=0, y_data=0, y_src=0, last_grant=1. With last_grant=1, requester 0 wins the first contention.
- State machine on the output slot:
  - EMPTY: y_valid=0.
  - FULL: y_valid=1.
- Slot can load: `load_ok = !y_valid || y_ready` (pass-through on drain).
- Grant rules, round-robin:
  - Only one requester valid: that requester wins.
  - Both valid: the requester opposite last_grant wins.
  - Neither valid: no grant; s holds its previous value.
- Acceptance: dN_ready = grant_N && load_ok. A transfer occurs when dN_valid && dN_ready. At most one of d0_ready and d1_ready is high per cycle.
- On transfer: y_data <= selected word, y_src <= winner, y_valid <= 1, last_grant <= winner.
- On y_ready && y_valid with no new transfer: y_valid <= 0. y_data and y_src keep their values.
- Drain and load in the same cycle: the slot stays FULL with the new word. No bubble.
- FULL with y_ready=0: both dN_ready=0. Upstream must hold valid and data stable; the arbiter does not re-arbitrate in a way that drops a word.
- A requester may deassert valid before it is accepted. The grant then re-evaluates next cycle.
- Reset mid-operation: the word in the slot is discarded, y_valid drops immediately (asynchronous), and last_grant returns to 1.

## Timing
- Latency: 1 cycle from accepted dN word to y_valid/y_data.
- Throughput: 1 word per cycle while y_ready=1.
- s and dN_ready are combinational from dN_valid, y_valid, y_ready and last_grant. y_* outputs are registered only.
- Fairness: under continuous contention with y_ready=1, grants alternate 0,1,0,1,...
- Worst-case wait for a valid requester is one transfer of the other requester.

## Configuration
- MUX2_ARB_FIXED_PRIO_EN defined:
  - Requester 0 always wins contention.
  - last_grant is not used for arbitration; y_src still reports the source.
  - Requester 1 may starve.
- MUX2_ARB_FIXED_PRIO_EN undefined: round-robin as specified above.

## Test plan
- Reset: assert rst mid-stream with y_valid=1 -> y_valid=0, y_data=0, y_src=0 immediately. First contention after reset grants d0.
- Single requester: d0_valid=1, d0_data=8'hA5, y_ready=1 -> next cycle y_valid=1, y_data=A5, y_src=0. s=0 during the accept cycle.
- Contention, round-robin: both valid for 4 cycles, d0_data=11, d1_data=22, y_ready=1 -> y_data sequence 11,22,11,22 and y_src sequence 0,1,0,1.
- Backpressure: slot FULL, y_ready=0 for 3 cycles, both requesters valid -> d0_ready=d1_ready=0 and y_data stable. When y_ready=1, the next word loads in the same cycle with no bubble.
- Valid withdrawal: d1 valid for 1 cycle while slot FULL, then deasserts -> no d1 transfer and y_src never 1.
- Fixed priority (macro defined): both valid for 4 cycles with y_ready=1 -> y_src = 0,0,0,0 and d1_ready never high.
